// File: rtl/tile_stream_merge.sv
// Round-robin merge of NUM_CH AXI-Stream inputs into one output stream.
// Whole packets are forwarded without interleaving; the source channel is
// reported on TID and completed packets are counted per channel.
module tile_stream_merge #(
  parameter int unsigned BW     = 32,
  parameter int unsigned BWB    = BW / 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_line,
  input  logic                    clk_line_rst_high,
  input  logic [NUM_CH-1:0]       stream_in_TVALID,
  input  logic [NUM_CH*BW-1:0]    stream_in_TDATA,
  input  logic [NUM_CH*BWB-1:0]   stream_in_TKEEP,
  input  logic [NUM_CH-1:0]       stream_in_TLAST,
  output logic [NUM_CH-1:0]       stream_in_TREADY,
  output logic                    stream_out_TVALID,
  input  logic                    stream_out_TREADY,
  output logic [BW-1:0]           stream_out_TDATA,
  output logic [BWB-1:0]          stream_out_TKEEP,
  output logic                    stream_out_TLAST,
  output logic [ID_W-1:0]         stream_out_TID,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic                    cnt_clear,
  output logic [NUM_CH*CNT_W-1:0] pkt_count
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   gnt_q;
  logic [ID_W-1:0]   last_q;
  logic              out_valid_q;
  logic [BW-1:0]     out_data_q;
  logic [BWB-1:0]    out_keep_q;
  logic              out_last_q;
  logic [ID_W-1:0]   out_tid_q;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  logic [BW-1:0]     in_data [NUM_CH];
  logic [BWB-1:0]    in_keep [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic              arb_found;
  logic [ID_W-1:0]   arb_pick;
  logic              out_free;
  logic              accept;
  logic              accept_last;
  logic [NUM_CH-1:0] in_ready;

  // Per-channel views of the flattened input buses and counter outputs
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign in_data[i] = stream_in_TDATA[i*BW +: BW];
    assign in_keep[i] = stream_in_TKEEP[i*BWB +: BWB];
    assign pkt_count[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign req         = stream_in_TVALID & ch_enable;
  assign out_free    = !out_valid_q || stream_out_TREADY;
  assign accept      = (state_q == ST_LOCK) && stream_in_TVALID[gnt_q] && out_free;
  assign accept_last = accept && stream_in_TLAST[gnt_q];

  // Round-robin search starting one past the last completed channel
  always_comb begin
    int unsigned idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_pick  = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = (32'(last_q) + k) % NUM_CH;
      if (!arb_found && req[ID_W'(idx)]) begin
        arb_found = 1'b1;
        arb_pick  = ID_W'(idx);
      end
    end
  end

  // Only the granted channel sees ready, and only while locked
  always_comb begin
    in_ready = '0;
    if (state_q == ST_LOCK) begin
      in_ready[gnt_q] = out_free;
    end
  end

  assign stream_in_TREADY = in_ready;

  // Arbitration FSM and output beat register
  always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
    if (clk_line_rst_high) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      last_q      <= ID_W'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_tid_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_found) begin
            gnt_q   <= arb_pick;
            state_q <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (accept_last) begin
            last_q  <= gnt_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data[gnt_q];
        out_keep_q  <= in_keep[gnt_q];
        out_last_q  <= stream_in_TLAST[gnt_q];
        out_tid_q   <= gnt_q;
      end else if (out_valid_q && stream_out_TREADY) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign stream_out_TVALID = out_valid_q;
  assign stream_out_TDATA  = out_data_q;
  assign stream_out_TKEEP  = out_keep_q;
  assign stream_out_TLAST  = out_last_q;
  assign stream_out_TID    = out_tid_q;

  // Saturating packet counters; clear takes priority over increment
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clear) begin
        cnt_d[i] = '0;
      end else if (accept_last && (gnt_q == ID_W'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Packet counter registers
  always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
    if (clk_line_rst_high) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule
